regfile_scoreboard: RTL

//   Parametrised multi-read-port register file with a per-register busy scoreboard.

---
 rtl/regfile_scoreboard_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 82 ++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard port bundle: read ports, writeback and issue claim.
// master = pipeline side (issue, decode, writeback); slave = regfile_scoreboard.
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRP   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;
    logic                iss_stall;
    logic [AW:0]         busy_cnt;

    modport master (
        output rd_addr, we, wa, wd, iss_valid, iss_addr,
        input  rd_data, rd_busy, iss_stall, busy_cnt
    );

    modport slave (
        input  rd_addr, we, wa, wd, iss_valid, iss_addr,
        output rd_data, rd_busy, iss_stall, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-read-port integer register file with per-register busy scoreboard (x0 = 0).
// Optional macro BYPASS_EN: same-cycle writeback forwarding to reads and issue stall.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRP   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [AW:0]      cnt;
    logic             wr_hit;
    logic             iss_busy;
    logic             claim;
    logic             clr;
    logic [AW-1:0]    ra;

    always_comb begin
        wr_hit   = bus.we && (bus.wa != '0);
        iss_busy = busy[bus.iss_addr] && (bus.iss_addr != '0);
`ifdef BYPASS_EN
        if (bus.we && (bus.wa == bus.iss_addr)) begin
            iss_busy = 1'b0;
        end
`endif
        bus.iss_stall = bus.iss_valid && iss_busy;
        claim = bus.iss_valid && !iss_busy && (bus.iss_addr != '0);
        clr   = wr_hit && busy[bus.wa];
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        ra          = '0;
        for (int p = 0; p < NRP; p++) begin
            ra = bus.rd_addr[p*AW +: AW];
            if (ra != '0) begin
                bus.rd_data[p*XLEN +: XLEN] = regs[ra];
                bus.rd_busy[p]              = busy[ra];
            end
`ifdef BYPASS_EN
            if (wr_hit && (bus.wa == ra)) begin
                bus.rd_data[p*XLEN +: XLEN] = bus.wd;
                bus.rd_busy[p]              = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    // Claim is applied after the writeback clear so a new producer keeps the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (wr_hit) begin
                busy[bus.wa] <= 1'b0;
            end
            if (claim) begin
                busy[bus.iss_addr] <= 1'b1;
            end
            cnt <= cnt + {{AW{1'b0}}, claim} - {{AW{1'b0}}, clr};
        end
    end

    assign bus.busy_cnt = cnt;
endmodule
